pulse_burst_sequencer: RTL and testbench
========================================

# pulse_burst_sequencer

Sequences bursts of square-wave pulses on the LED/pulser output. Software-side or top-level logic loads a half-period and a pulse count, strobes START, and the block emits exactly that many full pulses, then reports completion. It replaces free-running fixed-rate toggling with a programmable, abortable, handshaked sequence.

## Interface
Parameters:
- CNT_W, 35, width of half-period timer (matches 32 MHz clock, up to ~1000 s half-period)
- NUM_W, 16, width of pulse count

Ports:
- CLK  in  1  clock
- RST  in  1  reset; RST, synchronous, active-high; clock CLK
- START  in  1  single-cycle launch strobe, honoured only in IDLE
- STOP  in  1  abort strobe, honoured in any state
- HALF_PERIOD  in  CNT_W  cycles per high phase and per low phase, sampled on accepted START
- PULSE_COUNT  in  NUM_W  number of full pulses, sampled on accepted START
- PULSE  out  1  pulse output (drives LED)
- BUSY  out  1  high while a burst is active
- DONE  out  1  one-cycle completion strobe
- PULSES_LEFT  out  NUM_W  pulses remaining including the current one

## Operation
- States: IDLE, HIGH, LOW.
- IDLE: PULSE=0, BUSY=0. On START & ~STOP: latch HALF_PERIOD→hp, PULSE_COUNT→left, phase timer←0.
  - hp==0 or left==0 (macro absent): stay IDLE, assert DONE next cycle, no pulse.
  - otherwise → HIGH.
- HIGH: PULSE=1; timer counts 0..hp-1; at hp-1 → LOW, timer←0.
- LOW: PULSE=0; at hp-1: left←left-1; if left becomes 0 → IDLE with DONE=1; else → HIGH.
- STOP in HIGH/LOW: → IDLE next cycle, PULSE=0, left←0, DONE not asserted.
- START while BUSY ignored; inputs changing mid-burst have no effect (latched copies only).
- START and STOP same cycle in IDLE: STOP wins, nothing launched.
- Timer width CNT_W, compare with equality on hp-1; no wrap possible since timer resets at terminal value. left decrement never underflows (checked nonzero).

## Timing
- All outputs registered. Reset values: PULSE=0, BUSY=0, DONE=0, PULSES_LEFT=0, state IDLE.
- START accepted in cycle t → BUSY=1 and PULSE=1 from cycle t+1.
- Each pulse: exactly hp cycles high then hp cycles low; period 2·hp (hp=16000 at 32 MHz → 1 kHz).
- N pulses: BUSY high 2·hp·N cycles; DONE high for one cycle at t+1+2·hp·N, same cycle BUSY falls.
- Zero-length request: DONE at t+1, BUSY never rises.
- STOP in cycle s → PULSE=0, BUSY=0 at s+1.
- New START accepted in the DONE cycle (state already IDLE).
- RST mid-burst: all outputs to reset values next cycle, no DONE.

## Configuration
- PULSER_CONTINUOUS_EN defined: PULSE_COUNT==0 (with hp≠0) means run continuously; left held at 0, PULSES_LEFT=0, burst ends only via STOP or RST; DONE never asserted for such a run.
- Undefined: PULSE_COUNT==0 completes immediately with DONE as above.

## Structure
- Package pulser_pkg: state enum (IDLE, HIGH, LOW), default CNT_W=35, NUM_W=16, CLK_HZ=32_000_000 constant.
- Sub-module pulser_phase_timer: clearable up-counter of width CNT_W with terminal flag (count==hp-1); instantiated once.

## Test plan
- hp=4, count=3, START → PULSE pattern 4 high/4 low ×3, BUSY 24 cycles, DONE one cycle at t+25, PULSES_LEFT 3→2→1→0.
- hp=4, count=5, STOP during 2nd HIGH → PULSE=0, BUSY=0 next cycle, no DONE, PULSES_LEFT=0.
- count=0, hp=8 → macro absent: DONE at t+1, PULSE stays 0; macro present: continuous 8/8 toggling until STOP.
- START with STOP same cycle in IDLE, and START during burst → no launch / burst unaffected, latched hp/count unchanged after input changes.
- RST asserted mid-LOW → all outputs 0 next cycle; subsequent START with hp=1, count=2 → 1010 pattern, DONE at t+5.

Source files
------------

// File: rtl/pulse_burst_sequencer_pkg.sv
// Shared types and constants for the pulse burst sequencer.
// Optional feature macro: PULSER_CONTINUOUS_EN (see top file).
package pulser_pkg;

    localparam int DEF_CNT_W = 35;
    localparam int DEF_NUM_W = 16;
    localparam int CLK_HZ    = 32_000_000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2
    } state_t;

    // Half-period in clock cycles for a requested pulse frequency.
    function automatic int half_period_for_hz(input int hz);
        return CLK_HZ / (2 * hz);
    endfunction

endpackage

// File: rtl/pulse_burst_sequencer_if.sv
// Control/status bundle between the launching logic (master) and the sequencer (slave).
// Optional feature macro: none.
interface pulse_burst_sequencer_if
    import pulser_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W,
    parameter int NUM_W = DEF_NUM_W
);
    logic             START;
    logic             STOP;
    logic [CNT_W-1:0] HALF_PERIOD;
    logic [NUM_W-1:0] PULSE_COUNT;
    logic             PULSE;
    logic             BUSY;
    logic             DONE;
    logic [NUM_W-1:0] PULSES_LEFT;

    modport master (
        output START, STOP, HALF_PERIOD, PULSE_COUNT,
        input  PULSE, BUSY, DONE, PULSES_LEFT
    );

    modport slave (
        input  START, STOP, HALF_PERIOD, PULSE_COUNT,
        output PULSE, BUSY, DONE, PULSES_LEFT
    );
endinterface

// File: rtl/pulse_burst_sequencer_phase_timer.sv
// Clearable phase up-counter; flags the last cycle of a phase (count == hp-1).
// Optional feature macro: none.
module pulser_phase_timer
    import pulser_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             i_clr,
    input  logic             i_en,
    input  logic [CNT_W-1:0] i_hp,
    output logic             o_term
);
    logic [CNT_W-1:0] r_count;

    always_ff @(posedge CLK) begin
        if (RST || i_clr)
            r_count <= '0;
        else if (i_en)
            r_count <= r_count + CNT_W'(1);
    end

    assign o_term = (r_count == i_hp - CNT_W'(1));
endmodule

// File: rtl/pulse_burst_sequencer.sv
// Programmable, abortable burst of square pulses (hp high / hp low, N times).
// Optional feature macro: PULSER_CONTINUOUS_EN (PULSE_COUNT==0 runs until STOP/RST).
module pulse_burst_sequencer
    import pulser_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W,
    parameter int NUM_W = DEF_NUM_W
) (
    input  logic                      CLK,
    input  logic                      RST,
    pulse_burst_sequencer_if.slave    bus
);
    state_t           r_state;
    logic [CNT_W-1:0] r_hp;
    logic [NUM_W-1:0] r_left;
    logic             r_cont;
    logic             r_pulse;
    logic             r_busy;
    logic             r_done;

    logic             w_term;
    logic             w_clr;
    logic             w_zero_len;
    logic             w_cont_req;

`ifdef PULSER_CONTINUOUS_EN
    assign w_cont_req = (bus.PULSE_COUNT == '0);
    assign w_zero_len = (bus.HALF_PERIOD == '0);
`else
    assign w_cont_req = 1'b0;
    assign w_zero_len = (bus.HALF_PERIOD == '0) || (bus.PULSE_COUNT == '0);
`endif

    // Timer sits at zero while idle, so a launch always starts a fresh phase.
    assign w_clr = !r_busy || w_term || bus.STOP;

    pulser_phase_timer #(.CNT_W(CNT_W)) u_timer (
        .CLK    (CLK),
        .RST    (RST),
        .i_clr  (w_clr),
        .i_en   (r_busy),
        .i_hp   (r_hp),
        .o_term (w_term)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= IDLE;
            r_hp    <= '0;
            r_left  <= '0;
            r_cont  <= 1'b0;
            r_pulse <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (r_state != IDLE && bus.STOP) begin
                r_state <= IDLE;
                r_left  <= '0;
                r_cont  <= 1'b0;
                r_pulse <= 1'b0;
                r_busy  <= 1'b0;
            end else begin
                case (r_state)
                    IDLE: begin
                        if (bus.START && !bus.STOP) begin
                            r_hp <= bus.HALF_PERIOD;
                            if (w_zero_len) begin
                                r_left <= '0;
                                r_done <= 1'b1;
                            end else begin
                                r_left  <= bus.PULSE_COUNT;
                                r_cont  <= w_cont_req;
                                r_state <= HIGH;
                                r_pulse <= 1'b1;
                                r_busy  <= 1'b1;
                            end
                        end
                    end
                    HIGH: begin
                        if (w_term) begin
                            r_state <= LOW;
                            r_pulse <= 1'b0;
                        end
                    end
                    LOW: begin
                        if (w_term) begin
                            // r_left is nonzero here unless running continuously.
                            if (r_cont) begin
                                r_state <= HIGH;
                                r_pulse <= 1'b1;
                            end else if (r_left == NUM_W'(1)) begin
                                r_state <= IDLE;
                                r_left  <= '0;
                                r_busy  <= 1'b0;
                                r_done  <= 1'b1;
                            end else begin
                                r_left  <= r_left - NUM_W'(1);
                                r_state <= HIGH;
                                r_pulse <= 1'b1;
                            end
                        end
                    end
                    default: begin
                        r_state <= IDLE;
                        r_pulse <= 1'b0;
                        r_busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.PULSE       = r_pulse;
    assign bus.BUSY        = r_busy;
    assign bus.DONE        = r_done;
    assign bus.PULSES_LEFT = r_left;
endmodule

// File: tb/tb_pulse_burst_sequencer.sv
// Directed bench for pulse_burst_sequencer; outputs sampled on the falling edge.
// Observation word is {PULSE, BUSY, DONE, PULSES_LEFT}.
module tb_pulse_burst_sequencer;
    localparam int CNT_W = 35;
    localparam int NUM_W = 16;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    int   checks = 0;
    int   errors = 0;

    pulse_burst_sequencer_if #(.CNT_W(CNT_W), .NUM_W(NUM_W)) bus();

    pulse_burst_sequencer #(.CNT_W(CNT_W), .NUM_W(NUM_W)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    always #5 CLK = ~CLK;

    function automatic logic [18:0] ev(input bit p, input bit b, input bit d, input int l);
        return {p, b, d, 16'(l)};
    endfunction

    function automatic logic [18:0] obs();
        return {bus.PULSE, bus.BUSY, bus.DONE, bus.PULSES_LEFT};
    endfunction

    task automatic chk(input string tag, input logic [18:0] o, input logic [18:0] e);
        checks++;
        assert (o === e) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, o, e);
        end
    endtask

    task automatic launch(input int hp, input int cnt);
        bus.HALF_PERIOD = CNT_W'(hp);
        bus.PULSE_COUNT = NUM_W'(cnt);
        bus.START = 1'b1;
        @(negedge CLK);
        bus.START = 1'b0;
    endtask

    initial begin
        bus.START = 1'b0;
        bus.STOP = 1'b0;
        bus.HALF_PERIOD = '0;
        bus.PULSE_COUNT = '0;
        repeat (2) @(negedge CLK);
        chk("reset", obs(), ev(0, 0, 0, 0));
        RST = 1'b0;
        @(negedge CLK);
        chk("idle", obs(), ev(0, 0, 0, 0));

        // hp=4, count=3; START and new inputs mid-burst must be ignored
        launch(4, 3);
        for (int k = 1; k <= 24; k++) begin
            chk($sformatf("burst3 t+%0d", k), obs(),
                ev(((k - 1) % 8) < 4, 1, 0, 3 - (k - 1) / 8));
            if (k == 5) begin
                bus.START = 1'b1;
                bus.HALF_PERIOD = CNT_W'(2);
                bus.PULSE_COUNT = NUM_W'(9);
            end else begin
                bus.START = 1'b0;
            end
            @(negedge CLK);
        end
        chk("burst3 done", obs(), ev(0, 0, 1, 0));
        @(negedge CLK);
        chk("burst3 after", obs(), ev(0, 0, 0, 0));

        // hp=4, count=5, STOP during second HIGH
        launch(4, 5);
        repeat (9) @(negedge CLK);
        chk("stop pre", obs(), ev(1, 1, 0, 4));
        bus.STOP = 1'b1;
        @(negedge CLK);
        bus.STOP = 1'b0;
        chk("stop t+1", obs(), ev(0, 0, 0, 0));
        for (int k = 0; k < 3; k++) begin
            @(negedge CLK);
            chk("stop no done", obs(), ev(0, 0, 0, 0));
        end

        // count=0, hp=8
        launch(8, 0);
`ifdef PULSER_CONTINUOUS_EN
        for (int k = 1; k <= 32; k++) begin
            chk($sformatf("cont t+%0d", k), obs(), ev(((k - 1) % 16) < 8, 1, 0, 0));
            @(negedge CLK);
        end
        bus.STOP = 1'b1;
        @(negedge CLK);
        bus.STOP = 1'b0;
        chk("cont stop", obs(), ev(0, 0, 0, 0));
        @(negedge CLK);
        chk("cont no done", obs(), ev(0, 0, 0, 0));
`else
        chk("zero done", obs(), ev(0, 0, 1, 0));
        @(negedge CLK);
        chk("zero after", obs(), ev(0, 0, 0, 0));
`endif

        // START and STOP together in IDLE: nothing launches
        bus.HALF_PERIOD = CNT_W'(3);
        bus.PULSE_COUNT = NUM_W'(2);
        bus.START = 1'b1;
        bus.STOP = 1'b1;
        @(negedge CLK);
        bus.START = 1'b0;
        bus.STOP = 1'b0;
        chk("start+stop t+1", obs(), ev(0, 0, 0, 0));
        @(negedge CLK);
        chk("start+stop t+2", obs(), ev(0, 0, 0, 0));

        // RST mid-LOW
        launch(4, 3);
        repeat (5) @(negedge CLK);
        chk("rst pre", obs(), ev(0, 1, 0, 3));
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        chk("rst t+1", obs(), ev(0, 0, 0, 0));
        @(negedge CLK);
        chk("rst no done", obs(), ev(0, 0, 0, 0));

        // hp=1, count=2 -> 1010, DONE at t+5
        launch(1, 2);
        chk("hp1 t+1", obs(), ev(1, 1, 0, 2));
        @(negedge CLK);
        chk("hp1 t+2", obs(), ev(0, 1, 0, 2));
        @(negedge CLK);
        chk("hp1 t+3", obs(), ev(1, 1, 0, 1));
        @(negedge CLK);
        chk("hp1 t+4", obs(), ev(0, 1, 0, 1));
        @(negedge CLK);
        chk("hp1 done", obs(), ev(0, 0, 1, 0));

        // relaunch in the DONE cycle: hp=2, count=1
        launch(2, 1);
        chk("relaunch t+1", obs(), ev(1, 1, 0, 1));
        @(negedge CLK);
        chk("relaunch t+2", obs(), ev(1, 1, 0, 1));
        @(negedge CLK);
        chk("relaunch t+3", obs(), ev(0, 1, 0, 1));
        @(negedge CLK);
        chk("relaunch t+4", obs(), ev(0, 1, 0, 1));
        @(negedge CLK);
        chk("relaunch done", obs(), ev(0, 0, 1, 0));
        @(negedge CLK);
        chk("relaunch after", obs(), ev(0, 0, 0, 0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
